pulse_counter_stats: RTL and testbench
======================================

Name: pulse_counter_stats

Overview:
- Upstream statistics stage for the LCD draw sequencer.
- Takes one raw photon pulse count per gate period and scales it by the operator gain divider.
- Stores scaled counts in a 600-point ring buffer, one point per horizontal plot column.
- Produces the latest scaled count with an update strobe, a saturating accumulated total, and max/min over the buffered points, all consumed directly by the draw sequencer.

Parameters:
- DEPTH, 600, ring buffer points (one per plot column); must be ≤1023.
- AW, 10, buffer address / fill-count width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; when 0, new samples are ignored.
- iSample_Valid  in  1  one-cycle strobe, raw count valid.
- iSample  in  32  raw pulse count for the finished gate period.
- iGain_Divider  in  3  right-shift amount 0..7, sampled with iSample_Valid.
- iClear  in  1  one-cycle synchronous clear of statistics.
- oData_Update  out  1  one-cycle pulse, oPulse_Counter/oAccumulated refreshed.
- oPulse_Counter  out  32  latest scaled count.
- oAccumulated  out  32  saturating sum of scaled counts since reset/clear.
- oMax  out  16  maximum buffered point.
- oMin  out  16  minimum buffered point.
- oStats_Valid  out  1  one-cycle pulse, oMax/oMin refreshed.
- oFill_Count  out  AW  valid points in buffer, 0..DEPTH.
- oBusy  out  1  high in any state except IDLE.
- oOverrun  out  1  sticky; a sample was dropped.

Behaviour:
- Reset: clk and rst_n as already decided (asynchronous, active-low). Every output is 0 at reset. Write pointer = 0, pending register empty, state = IDLE. Buffer RAM contents are not reset.
- Scaling: scaled = iSample >> iGain_Divider (32-bit).
- Buffer word: the stored point is min(scaled, 16'hFFFF).
- Accumulation: oAccumulated += scaled, saturating at 32'hFFFFFFFF; it never wraps.
- Buffer: single-port synchronous RAM, DEPTH x 16, read latency 1.
- Write pointer: wraps DEPTH-1 → 0.
- oFill_Count: increments per write and saturates at DEPTH.
- State IDLE: accept a strobe (or the pending sample) when en=1. Latch scaled value → WRITE.
- State WRITE (T+1):
  - write the RAM at the pointer and advance the pointer;
  - update oPulse_Counter and oAccumulated;
  - update oFill_Count;
  - oData_Update=1 for this cycle.
  - → SCAN.
- State SCAN (T+2 .. T+N+1), where N = oFill_Count after the write: issue read addresses 0..N-1, one per cycle. Each read result is compared one cycle after its address into working max/min, seeded at 16'h0000 / 16'hFFFF.
- State FLUSH (T+N+2): compare the final read datum → DONE.
- State DONE (T+N+3): oMax/oMin take the working values; oStats_Valid=1 for this cycle → IDLE.
- Throughput: one sample completes every N+4 cycles. Max latency is DEPTH+4 = 604 cycles, far below any gate period.
- Strobe while oBusy=1: the sample and divider go into a one-deep pending register, processed on the next IDLE cycle. A strobe while the pending register is full is dropped and sets oOverrun.
- Strobe in the same cycle as DONE: goes to pending; no sample is lost.
- en=0: strobes ignored (not queued, no overrun); an operation already in progress still completes.
- iClear, any state: abort and return to IDLE next cycle. Zero oAccumulated, oFill_Count, pointer, oMax, oMin and oOverrun; empty pending. No oData_Update/oStats_Valid pulse.
- iClear together with iSample_Valid: clear wins; the sample is discarded.
- Empty buffer (after reset/clear): oMax = oMin = 0 until the first DONE.
- iSample = 0: legal. It is stored and participates in min.
- rst_n assertion mid-operation: immediate return to reset state; outputs 0 asynchronously.

Test Plan:
- Reset, strobe iSample=1000, divider=2 → oData_Update at T+2 with oPulse_Counter=250, oAccumulated=250. Then oStats_Valid at T+1+4 with oMax=oMin=250, oFill_Count=1.
- Strobe 32'h0003_0000, divider=0 → oPulse_Counter=196608, buffered point 16'hFFFF, oMax=16'hFFFF.
- oAccumulated=32'hFFFFFF00 (via prior samples), strobe 512 divider 0 → oAccumulated=32'hFFFFFFFF, held on further samples.
- 601 strobes with values 1..601, divider 0:
  - oFill_Count saturates at 600;
  - the 601st write lands at address 0;
  - final oMax=601, oMin=2.
- Three strobes back-to-back inside one SCAN → the second is processed after DONE, the third is dropped, oOverrun=1, oFill_Count increases by exactly 2. Then iClear → all statistics 0, oOverrun=0.
- iClear asserted mid-SCAN with 300 points loaded → oBusy low next cycle, no oStats_Valid, oMax=oMin=oFill_Count=0. The next strobe of 7 → oMax=oMin=7.

Source files
------------

// File: rtl/pulse_counter_stats_if.sv
// Sample/statistics bus between the gate-period front end and pulse_counter_stats.
// The master drives raw samples and control; the slave returns scaled data and statistics.
interface pulse_counter_stats_if #(
    parameter int AW = 10
);
    logic          en;
    logic          iSample_Valid;
    logic [31:0]   iSample;
    logic [2:0]    iGain_Divider;
    logic          iClear;

    logic          oData_Update;
    logic [31:0]   oPulse_Counter;
    logic [31:0]   oAccumulated;
    logic [15:0]   oMax;
    logic [15:0]   oMin;
    logic          oStats_Valid;
    logic [AW-1:0] oFill_Count;
    logic          oBusy;
    logic          oOverrun;

    modport master (
        output en, iSample_Valid, iSample, iGain_Divider, iClear,
        input  oData_Update, oPulse_Counter, oAccumulated, oMax, oMin,
               oStats_Valid, oFill_Count, oBusy, oOverrun
    );

    modport slave (
        input  en, iSample_Valid, iSample, iGain_Divider, iClear,
        output oData_Update, oPulse_Counter, oAccumulated, oMax, oMin,
               oStats_Valid, oFill_Count, oBusy, oOverrun
    );
endinterface

// File: rtl/pulse_counter_stats.sv
// Pulse-count statistics stage: scales each raw gate count, stores it in a
// DEPTH-point ring buffer (one point per plot column), keeps a saturating total
// and rescans the buffer after every write to refresh max/min for the LCD draw sequencer.
module pulse_counter_stats #(
    parameter int DEPTH = 600,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pulse_counter_stats_if.slave bus
);

    typedef enum logic [2:0] {IDLE, WRITE, SCAN, FLUSH, DONE} state_t;

    state_t        state, stateNext;

    // One-deep holding slot for a sample that arrives while an update is in flight.
    logic          pendValid;
    logic [31:0]   pendSample;
    logic [2:0]    pendDivider;
    logic          overrun;

    // Write side.
    logic [31:0]   latchedScaled;
    logic [31:0]   pulseCounter;
    logic [31:0]   accumulated;
    logic          dataUpdate;
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] fillCount;

    // Scan side.
    logic [AW-1:0] scanAddr;
    logic [15:0]   workMax, workMin;
    logic [15:0]   maxReg, minReg;
    logic          statsValid;

    // Point buffer.
    logic [15:0]   mem [DEPTH];
    logic          ramWe;
    logic [AW-1:0] ramAddr;
    logic [15:0]   ramWdata;
    logic [15:0]   ramRdata;

    logic          strobeIn, accept, takeLive, consumePend, pendStore, pendDrop;
    logic          scanLast, compareEn;
    logic [31:0]   srcScaled;
    logic [32:0]   accSum;

    // A strobe counts only when enabled; a simultaneous clear discards it.
    assign strobeIn    = bus.en && bus.iSample_Valid && !bus.iClear;
    // In IDLE the pending sample is older than any live strobe, so it goes first.
    assign accept      = (state == IDLE) && bus.en && !bus.iClear && (pendValid || bus.iSample_Valid);
    assign consumePend = accept && pendValid;
    assign takeLive    = accept && !pendValid;
    // A live strobe not taken directly is queued if the slot is free (or being freed this cycle).
    assign pendStore   = strobeIn && !takeLive && (!pendValid || consumePend);
    assign pendDrop    = strobeIn && pendValid && !consumePend;

    assign srcScaled   = pendValid ? (pendSample >> pendDivider) : (bus.iSample >> bus.iGain_Divider);
    assign accSum      = {1'b0, accumulated} + {1'b0, latchedScaled};

    // The RAM has one port: the write slot owns it in WRITE, the scan owns it otherwise.
    assign ramWe       = (state == WRITE) && !bus.iClear;
    assign ramAddr     = (state == WRITE) ? wrPtr : scanAddr;
    assign ramWdata    = (latchedScaled > 32'h0000_FFFF) ? 16'hFFFF : latchedScaled[15:0];

    // fillCount is already post-write while scanning, so it is never zero here.
    assign scanLast    = (scanAddr == fillCount - AW'(1));
    // Read data trails its address by one cycle: skip the first SCAN cycle, finish in FLUSH.
    assign compareEn   = ((state == SCAN) && (scanAddr != '0)) || (state == FLUSH);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic; clear aborts from any state.
    // NOTE: stateNext gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        stateNext = state;
        if (bus.iClear) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept) stateNext = WRITE;
                WRITE:   stateNext = SCAN;
                SCAN:    if (scanLast) stateNext = FLUSH;
                FLUSH:   stateNext = DONE;
                DONE:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Pending slot and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendValid   <= 1'b0;
            pendSample  <= '0;
            pendDivider <= '0;
            overrun     <= 1'b0;
        end else if (bus.iClear) begin
            pendValid   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (pendStore) begin
                pendValid   <= 1'b1;
                pendSample  <= bus.iSample;
                pendDivider <= bus.iGain_Divider;
            end else if (consumePend) begin
                pendValid   <= 1'b0;
            end
            if (pendDrop) overrun <= 1'b1;
        end
    end

    // Capture the scaled sample, then commit it: pointer, fill count, latest value and total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latchedScaled <= '0;
            pulseCounter  <= '0;
            accumulated   <= '0;
            wrPtr         <= '0;
            fillCount     <= '0;
            dataUpdate    <= 1'b0;
        end else begin
            dataUpdate <= 1'b0;
            if (bus.iClear) begin
                accumulated <= '0;
                wrPtr       <= '0;
                fillCount   <= '0;
            end else begin
                if (accept) latchedScaled <= srcScaled;
                if (state == WRITE) begin
                    pulseCounter <= latchedScaled;
                    accumulated  <= accSum[32] ? 32'hFFFF_FFFF : accSum[31:0];
                    wrPtr        <= (wrPtr == AW'(DEPTH - 1)) ? '0 : wrPtr + AW'(1);
                    if (fillCount != AW'(DEPTH)) fillCount <= fillCount + AW'(1);
                    dataUpdate   <= 1'b1;
                end
            end
        end
    end

    // Walk addresses 0..N-1, fold each returned point into the working max/min, publish at DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scanAddr   <= '0;
            workMax    <= 16'h0000;
            workMin    <= 16'hFFFF;
            maxReg     <= '0;
            minReg     <= '0;
            statsValid <= 1'b0;
        end else begin
            statsValid <= 1'b0;
            if (bus.iClear) begin
                scanAddr <= '0;
                maxReg   <= '0;
                minReg   <= '0;
            end else begin
                if (state == WRITE) begin
                    scanAddr <= '0;
                    workMax  <= 16'h0000;
                    workMin  <= 16'hFFFF;
                end
                if (state == SCAN) scanAddr <= scanAddr + AW'(1);
                if (compareEn) begin
                    if (ramRdata > workMax) workMax <= ramRdata;
                    if (ramRdata < workMin) workMin <= ramRdata;
                end
                if (state == DONE) begin
                    maxReg     <= workMax;
                    minReg     <= workMin;
                    statsValid <= 1'b1;
                end
            end
        end
    end

    // Single-port synchronous point buffer, read latency 1.
    // NOTE: the array has no reset; the fill count alone decides which points are meaningful.
    always_ff @(posedge clk) begin
        if (ramWe) mem[ramAddr] <= ramWdata;
        ramRdata <= mem[ramAddr];
    end

    assign bus.oData_Update   = dataUpdate;
    assign bus.oPulse_Counter = pulseCounter;
    assign bus.oAccumulated   = accumulated;
    assign bus.oMax           = maxReg;
    assign bus.oMin           = minReg;
    assign bus.oStats_Valid   = statsValid;
    assign bus.oFill_Count    = fillCount;
    assign bus.oBusy          = (state != IDLE);
    assign bus.oOverrun       = overrun;

endmodule

// File: tb/tb_pulse_counter_stats.sv
// Self-checking bench for pulse_counter_stats. A small ring-buffer model computes
// every expected value from the sample rules; the DUT runs with a reduced DEPTH so
// the wrap-around scenario stays short.
module tb_pulse_counter_stats;

    localparam int DEPTH = 64;
    localparam int AW    = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pulse_counter_stats_if #(.AW(AW)) bus ();

    pulse_counter_stats #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: plain array ring buffer with fill count and saturating total.
    int unsigned       mdlBuf [DEPTH];
    int                mdlPtr;
    int                mdlFill;
    longint unsigned   mdlAcc;

    function automatic void mdlClear();
        mdlPtr  = 0;
        mdlFill = 0;
        mdlAcc  = 0;
    endfunction

    function automatic int unsigned mdlPush(input int unsigned s, input int d);
        int unsigned scaled;
        scaled = s >> d;
        mdlBuf[mdlPtr] = (scaled > 65535) ? 65535 : scaled;
        mdlPtr = (mdlPtr + 1) % DEPTH;
        if (mdlFill < DEPTH) mdlFill++;
        mdlAcc = mdlAcc + scaled;
        if (mdlAcc > 64'hFFFF_FFFF) mdlAcc = 64'hFFFF_FFFF;
        return scaled;
    endfunction

    function automatic int unsigned mdlMax();
        int unsigned m = 0;
        for (int i = 0; i < mdlFill; i++) if (mdlBuf[i] > m) m = mdlBuf[i];
        return m;
    endfunction

    function automatic int unsigned mdlMin();
        int unsigned m = 65535;
        if (mdlFill == 0) return 0;
        for (int i = 0; i < mdlFill; i++) if (mdlBuf[i] < m) m = mdlBuf[i];
        return m;
    endfunction

    // Drive a one-cycle strobe; called and returns at a falling edge.
    task automatic pulseStrobe(input logic [31:0] s, input logic [2:0] d);
        bus.iSample       = s;
        bus.iGain_Divider = d;
        bus.iSample_Valid = 1'b1;
        @(negedge clk);
        bus.iSample_Valid = 1'b0;
    endtask

    task automatic issueClear();
        bus.iClear = 1'b1;
        @(negedge clk);
        bus.iClear = 1'b0;
        mdlClear();
    endtask

    task automatic waitIdle();
        for (int i = 0; i < DEPTH + 20 && bus.oBusy; i++) @(negedge clk);
        if (bus.oBusy !== 1'b0) begin
            testsRun++; testsFailed++;
            $display("FAIL idle_timeout: oBusy=%0b required 0", bus.oBusy);
        end
    endtask

    // which=0 waits for oData_Update, which=1 for oStats_Valid.
    task automatic waitPulse(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            if ((which == 0) ? bus.oData_Update : bus.oStats_Valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            testsRun++; testsFailed++;
            $display("FAIL pulse_timeout: no %s within bound", (which == 0) ? "oData_Update" : "oStats_Valid");
        end
    endtask

    // Full transaction from IDLE, checked against the model at both output pulses.
    task automatic runSample(input logic [31:0] s, input logic [2:0] d);
        logic [31:0] expPc;
        bit ok;
        waitIdle();
        expPc = mdlPush(s, d);
        pulseStrobe(s, d);
        waitPulse(0, ok);
        if (ok) begin
            testsRun++;
            if (bus.oPulse_Counter !== expPc) begin
                testsFailed++;
                $display("FAIL sample_pulse_counter: got %0d required %0d", bus.oPulse_Counter, expPc);
            end
            testsRun++;
            if (bus.oAccumulated !== 32'(mdlAcc)) begin
                testsFailed++;
                $display("FAIL sample_accumulated: got %0h required %0h", bus.oAccumulated, 32'(mdlAcc));
            end
        end
        waitPulse(1, ok);
        if (ok) begin
            testsRun++;
            if (bus.oMax !== 16'(mdlMax()) || bus.oMin !== 16'(mdlMin()) || bus.oFill_Count !== AW'(mdlFill)) begin
                testsFailed++;
                $display("FAIL sample_stats: got max=%0d min=%0d fill=%0d required max=%0d min=%0d fill=%0d",
                         bus.oMax, bus.oMin, bus.oFill_Count, mdlMax(), mdlMin(), mdlFill);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        testsRun++;
        if ({bus.oData_Update, bus.oPulse_Counter, bus.oAccumulated, bus.oMax, bus.oMin,
             bus.oStats_Valid, bus.oFill_Count, bus.oBusy, bus.oOverrun} !== '0) begin
            testsFailed++;
            $display("FAIL reset_outputs: pc=%0d acc=%0d max=%0d min=%0d fill=%0d busy=%0b ovr=%0b required all 0",
                     bus.oPulse_Counter, bus.oAccumulated, bus.oMax, bus.oMin, bus.oFill_Count, bus.oBusy, bus.oOverrun);
        end
        rst_n = 1'b1;
        @(negedge clk);
        testsRun++;
        if (bus.oBusy !== 1'b0 || bus.oFill_Count !== '0) begin
            testsFailed++;
            $display("FAIL reset_release: busy=%0b fill=%0d required 0 0", bus.oBusy, bus.oFill_Count);
        end
    endtask

    task automatic test_first_sample();
        void'(mdlPush(1000, 2));
        pulseStrobe(32'd1000, 3'd2);
        testsRun++;
        if (bus.oData_Update !== 1'b0) begin
            testsFailed++;
            $display("FAIL first_update_early: oData_Update=%0b required 0 at T+1", bus.oData_Update);
        end
        @(negedge clk);
        testsRun++;
        if (bus.oData_Update !== 1'b1 || bus.oPulse_Counter !== 32'd250 || bus.oAccumulated !== 32'd250) begin
            testsFailed++;
            $display("FAIL first_update: upd=%0b pc=%0d acc=%0d required 1 250 250",
                     bus.oData_Update, bus.oPulse_Counter, bus.oAccumulated);
        end
        repeat (3) @(negedge clk);
        testsRun++;
        if (bus.oStats_Valid !== 1'b1 || bus.oMax !== 16'd250 || bus.oMin !== 16'd250 || bus.oFill_Count !== AW'(1)) begin
            testsFailed++;
            $display("FAIL first_stats: sv=%0b max=%0d min=%0d fill=%0d required 1 250 250 1",
                     bus.oStats_Valid, bus.oMax, bus.oMin, bus.oFill_Count);
        end
    endtask

    task automatic test_big_sample();
        runSample(32'h0003_0000, 3'd0);
        testsRun++;
        if (bus.oPulse_Counter !== 32'd196608 || bus.oMax !== 16'hFFFF || bus.oMin !== 16'd250) begin
            testsFailed++;
            $display("FAIL big_sample: pc=%0d max=%0h min=%0d required 196608 ffff 250",
                     bus.oPulse_Counter, bus.oMax, bus.oMin);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] s;
            s = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 200000);
            runSample(s, 3'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_back_to_back();
        int fillBefore;
        logic [31:0] sA, sB, sC, expB;
        bit ok;
        sA = $urandom_range(1, 5000);
        sB = $urandom_range(1, 5000);
        sC = $urandom_range(1, 5000);
        waitIdle();
        fillBefore = mdlFill;
        void'(mdlPush(sA, 0));
        pulseStrobe(sA, 3'd0);
        @(negedge clk);
        testsRun++;
        if (bus.oData_Update !== 1'b1) begin
            testsFailed++;
            $display("FAIL b2b_first_update: oData_Update=%0b required 1", bus.oData_Update);
        end
        expB = mdlPush(sB, 0);
        pulseStrobe(sB, 3'd0);
        pulseStrobe(sC, 3'd0);
        waitPulse(1, ok);
        waitPulse(0, ok);
        if (ok) begin
            testsRun++;
            if (bus.oPulse_Counter !== expB || bus.oAccumulated !== 32'(mdlAcc)) begin
                testsFailed++;
                $display("FAIL b2b_second_update: pc=%0d acc=%0h required %0d %0h",
                         bus.oPulse_Counter, bus.oAccumulated, expB, 32'(mdlAcc));
            end
        end
        waitPulse(1, ok);
        if (ok) begin
            testsRun++;
            if (bus.oFill_Count !== AW'(fillBefore + 2) || bus.oMax !== 16'(mdlMax()) || bus.oMin !== 16'(mdlMin())) begin
                testsFailed++;
                $display("FAIL b2b_stats: fill=%0d max=%0d min=%0d required %0d %0d %0d",
                         bus.oFill_Count, bus.oMax, bus.oMin, fillBefore + 2, mdlMax(), mdlMin());
            end
        end
        repeat (DEPTH + 8) @(negedge clk);
        testsRun++;
        if (bus.oOverrun !== 1'b1 || bus.oBusy !== 1'b0 || bus.oFill_Count !== AW'(fillBefore + 2)) begin
            testsFailed++;
            $display("FAIL b2b_overrun: ovr=%0b busy=%0b fill=%0d required 1 0 %0d",
                     bus.oOverrun, bus.oBusy, bus.oFill_Count, fillBefore + 2);
        end
    endtask

    task automatic test_clear();
        waitIdle();
        issueClear();
        testsRun++;
        if (bus.oAccumulated !== '0 || bus.oFill_Count !== '0 || bus.oMax !== '0 || bus.oMin !== '0 ||
            bus.oOverrun !== 1'b0 || bus.oBusy !== 1'b0) begin
            testsFailed++;
            $display("FAIL clear_stats: acc=%0d fill=%0d max=%0d min=%0d ovr=%0b busy=%0b required all 0",
                     bus.oAccumulated, bus.oFill_Count, bus.oMax, bus.oMin, bus.oOverrun, bus.oBusy);
        end
    endtask

    task automatic test_saturation();
        waitIdle();
        issueClear();
        runSample(32'hFFFF_FF00, 3'd0);
        runSample(32'd512, 3'd0);
        testsRun++;
        if (bus.oAccumulated !== 32'hFFFF_FFFF) begin
            testsFailed++;
            $display("FAIL acc_saturate: got %0h required ffffffff", bus.oAccumulated);
        end
        runSample(32'd1000, 3'd0);
        testsRun++;
        if (bus.oAccumulated !== 32'hFFFF_FFFF) begin
            testsFailed++;
            $display("FAIL acc_hold: got %0h required ffffffff", bus.oAccumulated);
        end
    endtask

    task automatic test_wrap();
        waitIdle();
        issueClear();
        for (int v = 1; v <= DEPTH + 1; v++) runSample(32'(v), 3'd0);
        testsRun++;
        if (bus.oFill_Count !== AW'(DEPTH) || bus.oMax !== 16'(DEPTH + 1) || bus.oMin !== 16'd2) begin
            testsFailed++;
            $display("FAIL wrap: fill=%0d max=%0d min=%0d required %0d %0d 2",
                     bus.oFill_Count, bus.oMax, bus.oMin, DEPTH, DEPTH + 1);
        end
    endtask

    task automatic test_clear_mid_scan();
        bit seen;
        waitIdle();
        issueClear();
        for (int i = 0; i < 40; i++) runSample($urandom_range(1, 1000), 3'd0);
        waitIdle();
        pulseStrobe(32'd123, 3'd0);
        repeat (4) @(negedge clk);
        testsRun++;
        if (bus.oBusy !== 1'b1) begin
            testsFailed++;
            $display("FAIL midscan_busy: oBusy=%0b required 1", bus.oBusy);
        end
        bus.iClear = 1'b1;
        @(negedge clk);
        bus.iClear = 1'b0;
        mdlClear();
        testsRun++;
        if (bus.oBusy !== 1'b0 || bus.oMax !== '0 || bus.oMin !== '0 || bus.oFill_Count !== '0) begin
            testsFailed++;
            $display("FAIL midscan_clear: busy=%0b max=%0d min=%0d fill=%0d required all 0",
                     bus.oBusy, bus.oMax, bus.oMin, bus.oFill_Count);
        end
        seen = 1'b0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            if (bus.oStats_Valid || bus.oData_Update) seen = 1'b1;
            @(negedge clk);
        end
        testsRun++;
        if (seen !== 1'b0) begin
            testsFailed++;
            $display("FAIL midscan_no_pulse: pulse seen=%0b required 0", seen);
        end
        runSample(32'd7, 3'd0);
        testsRun++;
        if (bus.oMax !== 16'd7 || bus.oMin !== 16'd7) begin
            testsFailed++;
            $display("FAIL midscan_next: max=%0d min=%0d required 7 7", bus.oMax, bus.oMin);
        end
    endtask

    task automatic test_en_low();
        bit seen;
        waitIdle();
        bus.en = 1'b0;
        pulseStrobe(32'd999, 3'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.oBusy || bus.oData_Update) seen = 1'b1;
            @(negedge clk);
        end
        bus.en = 1'b1;
        repeat (4) @(negedge clk);
        testsRun++;
        if (seen !== 1'b0 || bus.oBusy !== 1'b0 || bus.oFill_Count !== AW'(mdlFill) || bus.oOverrun !== 1'b0) begin
            testsFailed++;
            $display("FAIL en_low: activity=%0b busy=%0b fill=%0d ovr=%0b required 0 0 %0d 0",
                     seen, bus.oBusy, bus.oFill_Count, bus.oOverrun, mdlFill);
        end
    endtask

    task automatic test_clear_with_strobe();
        bit seen;
        waitIdle();
        bus.iClear = 1'b1;
        pulseStrobe(32'd555, 3'd0);
        bus.iClear = 1'b0;
        mdlClear();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.oBusy || bus.oData_Update) seen = 1'b1;
            @(negedge clk);
        end
        testsRun++;
        if (seen !== 1'b0 || bus.oFill_Count !== '0 || bus.oAccumulated !== '0) begin
            testsFailed++;
            $display("FAIL clear_wins: activity=%0b fill=%0d acc=%0d required 0 0 0",
                     seen, bus.oFill_Count, bus.oAccumulated);
        end
    endtask

    task automatic test_zero_sample();
        runSample(32'd20, 3'd2);
        runSample(32'd0, 3'd0);
        testsRun++;
        if (bus.oMin !== 16'd0 || bus.oMax !== 16'd5 || bus.oPulse_Counter !== 32'd0) begin
            testsFailed++;
            $display("FAIL zero_sample: min=%0d max=%0d pc=%0d required 0 5 0", bus.oMin, bus.oMax, bus.oPulse_Counter);
        end
    endtask

    task automatic test_reset_mid_op();
        runSample(32'd500, 3'd1);
        waitIdle();
        pulseStrobe(32'd900, 3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({bus.oData_Update, bus.oPulse_Counter, bus.oAccumulated, bus.oMax, bus.oMin,
             bus.oStats_Valid, bus.oFill_Count, bus.oBusy, bus.oOverrun} !== '0) begin
            testsFailed++;
            $display("FAIL async_reset: pc=%0d acc=%0d max=%0d min=%0d fill=%0d busy=%0b required all 0",
                     bus.oPulse_Counter, bus.oAccumulated, bus.oMax, bus.oMin, bus.oFill_Count, bus.oBusy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mdlClear();
        @(negedge clk);
        runSample(32'd44, 3'd2);
    endtask

    initial begin
        bus.en            = 1'b1;
        bus.iSample_Valid = 1'b0;
        bus.iSample       = '0;
        bus.iGain_Divider = '0;
        bus.iClear        = 1'b0;
        mdlClear();

        test_reset();
        test_first_sample();
        test_big_sample();
        test_random();
        test_back_to_back();
        test_clear();
        test_saturation();
        test_wrap();
        test_clear_mid_scan();
        test_en_low();
        test_clear_with_strobe();
        test_zero_sample();
        test_reset_mid_op();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
